// File: rtl/icache_data_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : icache_data_ctrl
// Purpose  : Sequencer for the I-cache data SRAM (64 lines x 128 bits, 1RW,
//            per-beat write mask). Arbitrates fetch reads against two-beat
//            line refills. It drives the SRAM pins directly and returns read
//            data one cycle after a read is granted. A fetch redirect (kill)
//            drops an in-flight read.
// Revision : 1.0  initial release
// ============================================================================
module icache_data_ctrl #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 128,
    parameter int BEAT_WIDTH = 64,
    parameter int NUM_WMASKS = 2
) (
    input  logic                  clk,
    input  logic                  rst_aL,
    // fetch read port
    input  logic                  rd_valid,
    input  logic [ADDR_WIDTH-1:0] rd_index,
    output logic                  rd_ready,
    input  logic                  kill,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    // refill port
    input  logic                  fill_req_valid,
    input  logic [ADDR_WIDTH-1:0] fill_index,
    output logic                  fill_req_ready,
    input  logic                  fill_valid,
    input  logic [BEAT_WIDTH-1:0] fill_data,
    output logic                  fill_ready,
    output logic                  fill_done,
    // SRAM pins
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
);

    // The low beat lands in mask lane 0 and the high beat in lane 1.
    localparam logic [NUM_WMASKS-1:0] c_wmask_lo = NUM_WMASKS'(1);
    localparam logic [NUM_WMASKS-1:0] c_wmask_hi = NUM_WMASKS'(2);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL_LO = 2'd1,
        ST_FILL_HI = 2'd2
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_fill_idx;
    logic                  r_rsp_valid;
    logic                  r_fill_done;

    logic w_in_fill;
    logic w_beat;
    logic w_start;
    logic w_hazard;
    logic w_rd_grant;

    // Arbitration: beat write first, then fill start, then read. While a
    // refill is active, reads to that line are held off until it completes.
    assign w_in_fill  = (r_state == ST_FILL_LO) || (r_state == ST_FILL_HI);
    assign w_beat     = w_in_fill && fill_valid;
    assign w_start    = (r_state == ST_IDLE) && fill_req_valid;
    assign w_hazard   = w_in_fill && (rd_index == r_fill_idx);
    assign w_rd_grant = rd_valid && !w_start && !w_beat && !w_hazard;

    assign rd_ready       = w_rd_grant;
    assign fill_req_ready = (r_state == ST_IDLE);
    assign fill_ready     = w_in_fill;
    assign fill_done      = r_fill_done;

    // A kill in the response cycle suppresses the response immediately.
    assign rsp_valid = r_rsp_valid && !kill;
    assign rsp_data  = sram_dout0;

    // SRAM pins are combinational from the arbitration result. The beat is
    // replicated across both halves, and the mask selects the half to write.
    assign sram_csb0   = !(w_beat || w_rd_grant);
    assign sram_web0   = !w_beat;
    assign sram_wmask0 = !w_beat                  ? '0 :
                         (r_state == ST_FILL_LO)  ? c_wmask_lo : c_wmask_hi;
    assign sram_addr0  = w_beat ? r_fill_idx : rd_index;
    assign sram_din0   = {NUM_WMASKS{fill_data}};

    // Refill sequencing, fill index latch, response valid and done pulse.
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            r_state     <= ST_IDLE;
            r_fill_idx  <= '0;
            r_rsp_valid <= 1'b0;
            r_fill_done <= 1'b0;
        end else begin
            r_fill_done <= 1'b0;
            r_rsp_valid <= w_rd_grant && !kill;
            case (r_state)
                ST_IDLE: begin
                    if (fill_req_valid) begin
                        r_state    <= ST_FILL_LO;
                        r_fill_idx <= fill_index;
                    end
                end
                ST_FILL_LO: begin
                    if (fill_valid) begin
                        r_state <= ST_FILL_HI;
                    end
                end
                ST_FILL_HI: begin
                    if (fill_valid) begin
                        r_state     <= ST_IDLE;
                        r_fill_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_data_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_data_ctrl
// Purpose  : Self-checking bench for icache_data_ctrl. It contains a 1RW SRAM
//            model on the DUT pins and a line-level reference model of the
//            expected cache contents and controller behaviour.
// Revision : 1.0  initial release
// ============================================================================
module tb_icache_data_ctrl;

    logic         clk = 1'b0;
    logic         rst_aL;
    logic         rd_valid;
    logic [5:0]   rd_index;
    logic         rd_ready;
    logic         kill;
    logic         rsp_valid;
    logic [127:0] rsp_data;
    logic         fill_req_valid;
    logic [5:0]   fill_index;
    logic         fill_req_ready;
    logic         fill_valid;
    logic [63:0]  fill_data;
    logic         fill_ready;
    logic         fill_done;
    logic         sram_csb0;
    logic         sram_web0;
    logic [1:0]   sram_wmask0;
    logic [5:0]   sram_addr0;
    logic [127:0] sram_din0;
    logic [127:0] sram_dout0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_data_ctrl #(
        .ADDR_WIDTH(6), .DATA_WIDTH(128), .BEAT_WIDTH(64), .NUM_WMASKS(2)
    ) dut (
        .clk(clk), .rst_aL(rst_aL),
        .rd_valid(rd_valid), .rd_index(rd_index), .rd_ready(rd_ready),
        .kill(kill), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .fill_req_valid(fill_req_valid), .fill_index(fill_index),
        .fill_req_ready(fill_req_ready), .fill_valid(fill_valid),
        .fill_data(fill_data), .fill_ready(fill_ready), .fill_done(fill_done),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
    );

    // SRAM macro model: pins are sampled at the posedge, and read data is held
    // until the next read.
    logic [127:0] sram_mem [64] = '{default: '0};
    logic [127:0] sram_q = '0;
    assign sram_dout0 = sram_q;

    always @(posedge clk) begin
        if (!sram_csb0) begin
            if (!sram_web0) begin
                if (sram_wmask0[0]) sram_mem[sram_addr0][63:0]   <= sram_din0[63:0];
                if (sram_wmask0[1]) sram_mem[sram_addr0][127:64] <= sram_din0[127:64];
            end else begin
                sram_q <= sram_mem[sram_addr0];
            end
        end
    end

    // ---------------- reference model ----------------
    logic [127:0] ref_mem [64] = '{default: '0};
    int           m_phase;   // 0: no refill, 1: waiting low beat, 2: waiting high beat
    logic [5:0]   m_idx;
    bit           m_done;
    bit           m_pend;
    logic [127:0] m_rsp;

    logic e_rd_ready, e_frr, e_fr, e_beat, e_start, e_csb, e_web, e_rsp_valid, e_done;
    logic [1:0]   e_wmask;
    logic [5:0]   e_addr;
    logic [127:0] e_din;

    task automatic model_reset();
        m_phase = 0;
        m_idx   = '0;
        m_done  = 0;
        m_pend  = 0;
    endtask

    task automatic model_eval();
        e_frr       = (m_phase == 0);
        e_fr        = (m_phase != 0);
        e_beat      = e_fr && fill_valid;
        e_start     = e_frr && fill_req_valid;
        e_rd_ready  = rd_valid && !e_start && !e_beat && !(e_fr && rd_index == m_idx);
        e_csb       = !(e_beat || e_rd_ready);
        e_web       = !e_beat;
        e_wmask     = !e_beat ? 2'b00 : (m_phase == 1 ? 2'b01 : 2'b10);
        e_addr      = e_beat ? m_idx : rd_index;
        e_din       = {fill_data, fill_data};
        e_rsp_valid = m_pend && !kill;
        e_done      = m_done;
    endtask

    task automatic model_commit();
        m_done = 0;
        if (e_beat) begin
            if (m_phase == 1) begin
                ref_mem[m_idx][63:0] = fill_data;
                m_phase = 2;
            end else begin
                ref_mem[m_idx][127:64] = fill_data;
                m_phase = 0;
                m_done  = 1;
            end
        end else if (e_start) begin
            m_phase = 1;
            m_idx   = fill_index;
        end
        m_pend = e_rd_ready && !kill;
        if (e_rd_ready) m_rsp = ref_mem[rd_index];
    endtask

    // Apply one cycle of inputs after the falling edge and evaluate the model.
    task automatic drive(input logic rv, input logic [5:0] ri, input logic k,
                         input logic frv, input logic [5:0] fi,
                         input logic fv, input logic [63:0] fd);
        @(negedge clk);
        rd_valid = rv; rd_index = ri; kill = k;
        fill_req_valid = frv; fill_index = fi;
        fill_valid = fv; fill_data = fd;
        #1;
        model_eval();
    endtask

    task automatic adv();
        @(posedge clk);
        model_commit();
    endtask

    task automatic idle();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 64'd0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_aL = 1'b0;
        model_reset();
        idle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL reset_fill_done got %b want 0", fill_done); end
        checks++; if ({sram_csb0, sram_web0, sram_wmask0} !== 4'b1100) begin errors++; $display("FAIL reset_sram_pins got %b want 1100", {sram_csb0, sram_web0, sram_wmask0}); end
        checks++; if ({fill_req_ready, fill_ready} !== 2'b10) begin errors++; $display("FAIL reset_ready got %b want 10", {fill_req_ready, fill_ready}); end
        @(negedge clk);
        rst_aL = 1'b1;
    endtask

    task automatic test_read_after_reset();
        drive(1'b1, 6'd5, 1'b0, 1'b0, 6'd0, 1'b0, 64'd0);
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rd5_ready got %b want 1", rd_ready); end
        checks++; if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0} !== {4'b0100, 6'd5}) begin errors++; $display("FAIL rd5_pins got %b want 0100_000101", {sram_csb0, sram_web0, sram_wmask0, sram_addr0}); end
        adv();
        idle();
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL rd5_rsp_valid got %b want 1", rsp_valid); end
        checks++; if (rsp_data !== 128'd0) begin errors++; $display("FAIL rd5_rsp_data got %h want 0", rsp_data); end
        adv();
    endtask

    task automatic test_fill();
        logic [63:0] a, b;
        a = 64'hAAAA_AAAA_AAAA_AAAA;
        b = 64'h5555_5555_5555_5555;
        drive(1'b0, 6'd0, 1'b0, 1'b1, 6'd3, 1'b0, 64'd0);
        checks++; if (fill_req_ready !== 1'b1) begin errors++; $display("FAIL fill_start_ready got %b want 1", fill_req_ready); end
        adv();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, a);
        checks++; if ({fill_ready, sram_csb0, sram_web0, sram_wmask0, sram_addr0} !== {5'b10001, 6'd3}) begin errors++; $display("FAIL fill_lo_pins got %b want 10001_000011", {fill_ready, sram_csb0, sram_web0, sram_wmask0, sram_addr0}); end
        checks++; if (sram_din0 !== {a, a}) begin errors++; $display("FAIL fill_lo_din got %h want %h", sram_din0, {a, a}); end
        adv();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, b);
        checks++; if ({sram_csb0, sram_web0, sram_wmask0, sram_addr0} !== {4'b0010, 6'd3}) begin errors++; $display("FAIL fill_hi_pins got %b want 0010_000011", {sram_csb0, sram_web0, sram_wmask0, sram_addr0}); end
        checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL fill_done_early got %b want 0", fill_done); end
        adv();
        idle();
        checks++; if (fill_done !== 1'b1) begin errors++; $display("FAIL fill_done_pulse got %b want 1", fill_done); end
        adv();
        drive(1'b1, 6'd3, 1'b0, 1'b0, 6'd0, 1'b0, 64'd0);
        checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL fill_done_once got %b want 0", fill_done); end
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL rd3_ready got %b want 1", rd_ready); end
        adv();
        idle();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== {b, a}) begin errors++; $display("FAIL rd3_data got %b/%h want 1/%h", rsp_valid, rsp_data, {b, a}); end
        adv();
    endtask

    task automatic test_fill_hazard();
        logic [63:0] b0, b1, c0, c1;
        b0 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        c0 = {$urandom, $urandom}; c1 = {$urandom, $urandom};
        drive(1'b0, 6'd0, 1'b0, 1'b1, 6'd4, 1'b0, 64'd0); adv();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, b0);    adv();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, b1);    adv();
        idle(); adv();
        drive(1'b1, 6'd3, 1'b0, 1'b1, 6'd3, 1'b0, 64'd0);
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL hz_start_rd got %b want 0", rd_ready); end
        adv();
        drive(1'b1, 6'd3, 1'b0, 1'b0, 6'd0, 1'b0, 64'd0);
        checks++; if (rd_ready !== 1'b0 || sram_csb0 !== 1'b1) begin errors++; $display("FAIL hz_gap_same got %b%b want 01", rd_ready, sram_csb0); end
        adv();
        drive(1'b1, 6'd3, 1'b0, 1'b0, 6'd0, 1'b1, c0);
        checks++; if (rd_ready !== 1'b0 || sram_wmask0 !== 2'b01) begin errors++; $display("FAIL hz_lo got %b%b want 0_01", rd_ready, sram_wmask0); end
        adv();
        drive(1'b1, 6'd4, 1'b0, 1'b0, 6'd0, 1'b0, 64'd0);
        checks++; if (rd_ready !== 1'b1 || sram_addr0 !== 6'd4) begin errors++; $display("FAIL hz_gap_other got %b/%0d want 1/4", rd_ready, sram_addr0); end
        adv();
        drive(1'b1, 6'd3, 1'b0, 1'b0, 6'd0, 1'b1, c1);
        checks++; if (rd_ready !== 1'b0) begin errors++; $display("FAIL hz_hi_rd got %b want 0", rd_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== {b1, b0}) begin errors++; $display("FAIL hz_rd4_data got %b/%h want 1/%h", rsp_valid, rsp_data, {b1, b0}); end
        adv();
        drive(1'b1, 6'd3, 1'b0, 1'b0, 6'd0, 1'b0, 64'd0);
        checks++; if (rd_ready !== 1'b1 || fill_done !== 1'b1) begin errors++; $display("FAIL hz_release got %b%b want 11", rd_ready, fill_done); end
        adv();
        idle();
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== {c1, c0}) begin errors++; $display("FAIL hz_rd3_data got %b/%h want 1/%h", rsp_valid, rsp_data, {c1, c0}); end
        adv();
    endtask

    task automatic test_same_cycle();
        drive(1'b1, 6'd10, 1'b0, 1'b1, 6'd11, 1'b0, 64'd0);
        checks++; if (rd_ready !== 1'b0 || fill_req_ready !== 1'b1) begin errors++; $display("FAIL sc_start got %b%b want 01", rd_ready, fill_req_ready); end
        adv();
        drive(1'b1, 6'd10, 1'b0, 1'b0, 6'd0, 1'b1, {$urandom, $urandom});
        checks++; if (rd_ready !== 1'b0 || sram_web0 !== 1'b0) begin errors++; $display("FAIL sc_beat_blocks got %b%b want 00", rd_ready, sram_web0); end
        adv();
        drive(1'b1, 6'd10, 1'b0, 1'b0, 6'd0, 1'b0, 64'd0);
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL sc_gap_grant got %b want 1", rd_ready); end
        adv();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, {$urandom, $urandom});
        checks++; if (rsp_valid !== 1'b1 || rsp_data !== ref_mem[10]) begin errors++; $display("FAIL sc_rsp got %b/%h want 1/%h", rsp_valid, rsp_data, ref_mem[10]); end
        adv();
        idle();
        checks++; if (fill_done !== 1'b1) begin errors++; $display("FAIL sc_done got %b want 1", fill_done); end
        adv();
    endtask

    task automatic test_kill();
        drive(1'b1, 6'd3, 1'b1, 1'b0, 6'd0, 1'b0, 64'd0);
        checks++; if (rd_ready !== 1'b1) begin errors++; $display("FAIL kill_grant got %b want 1", rd_ready); end
        adv();
        drive(1'b1, 6'd4, 1'b0, 1'b0, 6'd0, 1'b0, 64'd0);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL kill_grant_rsp got %b want 0", rsp_valid); end
        adv();
        drive(1'b0, 6'd0, 1'b1, 1'b0, 6'd0, 1'b0, 64'd0);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL kill_rsp_cycle got %b want 0", rsp_valid); end
        adv();
        idle();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL kill_after got %b want 0", rsp_valid); end
        adv();
    endtask

    task automatic test_reset_mid_fill();
        drive(1'b0, 6'd0, 1'b0, 1'b1, 6'd9, 1'b0, 64'd0); adv();
        drive(1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, {$urandom, $urandom}); adv();
        @(negedge clk);
        fill_valid = 1'b1; fill_data = {$urandom, $urandom};
        rst_aL = 1'b0;
        #1;
        model_reset();
        checks++; if ({fill_ready, fill_req_ready, sram_csb0, sram_web0, sram_wmask0} !== 6'b011100) begin errors++; $display("FAIL rst_mid_pins got %b want 011100", {fill_ready, fill_req_ready, sram_csb0, sram_web0, sram_wmask0}); end
        checks++; if (rsp_valid !== 1'b0 || fill_done !== 1'b0) begin errors++; $display("FAIL rst_mid_outs got %b%b want 00", rsp_valid, fill_done); end
        @(posedge clk);
        @(negedge clk);
        rst_aL = 1'b1;
        #1;
        model_eval();
        checks++; if (fill_ready !== 1'b0 || sram_csb0 !== 1'b1) begin errors++; $display("FAIL rst_beat_ignored got %b%b want 01", fill_ready, sram_csb0); end
        adv();
        idle();
        checks++; if (fill_done !== 1'b0) begin errors++; $display("FAIL rst_no_done got %b want 0", fill_done); end
        adv();
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            drive($urandom_range(0, 1) == 1,
                  ($urandom_range(0, 2) == 0) ? m_idx : 6'($urandom_range(0, 15)),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3) == 0,
                  6'($urandom_range(0, 15)),
                  $urandom_range(0, 2) != 0,
                  {$urandom, $urandom});
            checks++; if ({rd_ready, fill_req_ready, fill_ready, rsp_valid, fill_done} !== {e_rd_ready, e_frr, e_fr, e_rsp_valid, e_done}) begin errors++; $display("FAIL rnd_ctl cyc %0d got %b want %b", n, {rd_ready, fill_req_ready, fill_ready, rsp_valid, fill_done}, {e_rd_ready, e_frr, e_fr, e_rsp_valid, e_done}); end
            checks++; if ({sram_csb0, sram_web0, sram_wmask0} !== {e_csb, e_web, e_wmask}) begin errors++; $display("FAIL rnd_pins cyc %0d got %b want %b", n, {sram_csb0, sram_web0, sram_wmask0}, {e_csb, e_web, e_wmask}); end
            if (!e_csb) begin
                checks++; if (sram_addr0 !== e_addr) begin errors++; $display("FAIL rnd_addr cyc %0d got %0d want %0d", n, sram_addr0, e_addr); end
            end
            if (e_beat) begin
                checks++; if (sram_din0 !== e_din) begin errors++; $display("FAIL rnd_din cyc %0d got %h want %h", n, sram_din0, e_din); end
            end
            if (e_rsp_valid) begin
                checks++; if (rsp_data !== m_rsp) begin errors++; $display("FAIL rnd_data cyc %0d got %h want %h", n, rsp_data, m_rsp); end
            end
            adv();
        end
    endtask

    initial begin
        rd_valid = 1'b0; rd_index = '0; kill = 1'b0;
        fill_req_valid = 1'b0; fill_index = '0;
        fill_valid = 1'b0; fill_data = '0;
        rst_aL = 1'b0;
        m_rsp = '0;
        test_reset();
        test_read_after_reset();
        test_fill();
        test_fill_hazard();
        test_same_cycle();
        test_kill();
        test_reset_mid_fill();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
